// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - client-side and controller-side bus bundle for sdram_arbiter
interface sdram_arbiter_if #(
    parameter int N  = 3,
    parameter int AW = 24,
    parameter int DW = 16,
    parameter int LW = 9
);
    logic [N-1:0]    C_REQ;
    logic [N-1:0]    C_WRITE;
    logic [N*AW-1:0] C_ADDR;
    logic [N*LW-1:0] C_LEN;
    logic [N*DW-1:0] C_WDATA;
    logic [N-1:0]    C_GNT;
    logic [LW-1:0]   C_XLEN;
    logic [N-1:0]    C_WR_ADV;
    logic [N-1:0]    C_RD_ADV;
    logic [DW-1:0]   C_RDATA;
    logic [N-1:0]    C_DONE;
    logic            ERR;
    logic [LW-1:0]   S_LENGTH;
    logic [LW-1:0]   S_MAX_LEN;
    logic [AW-1:0]   S_ADDR;
    logic [DW-1:0]   S_DATA_IN;
    logic [DW-1:0]   S_DATA_OUT;
    logic            S_REQUEST;
    logic            S_WRITE;
    logic            S_BUSY;
    logic            S_WR_ADV;
    logic            S_RD_ADV;

    modport slave (
        input  C_REQ, C_WRITE, C_ADDR, C_LEN, C_WDATA,
        input  S_MAX_LEN, S_DATA_OUT, S_BUSY, S_WR_ADV, S_RD_ADV,
        output C_GNT, C_XLEN, C_WR_ADV, C_RD_ADV, C_RDATA, C_DONE, ERR,
        output S_LENGTH, S_ADDR, S_DATA_IN, S_REQUEST, S_WRITE
    );

    modport master (
        output C_REQ, C_WRITE, C_ADDR, C_LEN, C_WDATA,
        output S_MAX_LEN, S_DATA_OUT, S_BUSY, S_WR_ADV, S_RD_ADV,
        input  C_GNT, C_XLEN, C_WR_ADV, C_RD_ADV, C_RDATA, C_DONE, ERR,
        input  S_LENGTH, S_ADDR, S_DATA_IN, S_REQUEST, S_WRITE
    );
endinterface

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - round-robin arbiter sharing one sdram controller port between N masters
// Re-issues a request when a controller auto-refresh swallows it (no beats seen).
module sdram_arbiter #(
    parameter int N     = 3,
    parameter int AW    = 24,
    parameter int DW    = 16,
    parameter int LW    = 9,
    parameter int DRAIN = 2
) (
    input logic         CLK,
    input logic         RESET,
    sdram_arbiter_if.slave bus
);
    localparam int OW  = (N > 1) ? $clog2(N) : 1;
    localparam int DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam logic [OW:0] NW = (OW+1)'(N);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER, S_DRAIN} state_t;
    state_t state, state_nx;

    logic [OW-1:0]  owner, ptr, pick;
    logic           pick_vld;
    logic [OW:0]    scan;
    logic [N-1:0]   pick_onehot;
    logic [LW-1:0]  xlen;
    logic [LW:0]    beats, beats_now;
    logic           beat_inc;
    logic [DCW-1:0] dcnt;
    logic           drain_last;
    logic [AW-1:0]  addr_r;
    logic           write_r;
    logic [N-1:0]   gnt, done;
    logic           err;

    logic [LW-1:0]  len_a   [N];
    logic [AW-1:0]  addr_a  [N];
    logic [DW-1:0]  wdata_a [N];

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign len_a[g]   = bus.C_LEN[g*LW +: LW];
        assign addr_a[g]  = bus.C_ADDR[g*AW +: AW];
        assign wdata_a[g] = bus.C_WDATA[g*DW +: DW];
    end

    // First requester strictly after ptr, wrapping, so the last owner has lowest priority.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        scan     = '0;
        for (int k = 1; k <= N; k++) begin
            scan = {1'b0, ptr} + (OW+1)'(k);
            if (scan >= NW) scan = scan - NW;
            if (!pick_vld && bus.C_REQ[scan[OW-1:0]]) begin
                pick_vld = 1'b1;
                pick     = scan[OW-1:0];
            end
        end
    end

    assign pick_onehot = {{(N-1){1'b0}}, 1'b1} << pick;
    assign beat_inc    = ((state == S_XFER) && (bus.S_WR_ADV || bus.S_RD_ADV)) ||
                         ((state == S_DRAIN) && bus.S_RD_ADV);
    assign beats_now   = beats + {{LW{1'b0}}, beat_inc};
    assign drain_last  = (state == S_DRAIN) && (dcnt == DCW'(DRAIN - 1));

    always_ff @(posedge CLK) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (pick_vld)      state_nx = S_ISSUE;
            S_ISSUE: if (bus.S_BUSY)    state_nx = S_XFER;
            S_XFER:  if (!bus.S_BUSY)   state_nx = S_DRAIN;
            S_DRAIN: if (drain_last)    state_nx = (beats_now == '0) ? S_ISSUE : S_IDLE;
            default:                    state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            owner   <= '0;
            ptr     <= OW'(N - 1);
            xlen    <= '0;
            addr_r  <= '0;
            write_r <= 1'b0;
            beats   <= '0;
            dcnt    <= '0;
            gnt     <= '0;
            done    <= '0;
            err     <= 1'b0;
        end else begin
            done <= '0;
            case (state)
                S_IDLE: begin
                    beats <= '0;
                    dcnt  <= '0;
                    if (pick_vld) begin
                        owner   <= pick;
                        ptr     <= pick;
                        xlen    <= (len_a[pick] < bus.S_MAX_LEN) ? len_a[pick] : bus.S_MAX_LEN;
                        addr_r  <= addr_a[pick];
                        write_r <= bus.C_WRITE[pick];
                        gnt     <= pick_onehot;
                    end
                end
                S_XFER: beats <= beats_now;
                S_DRAIN: begin
                    beats <= beats_now;
                    dcnt  <= dcnt + DCW'(1);
                    if (drain_last) begin
                        dcnt <= '0;
                        // Zero beats means refresh ate the request: retry with the same latched burst.
                        if (beats_now == '0) begin
                            beats <= '0;
                        end else begin
                            if (beats_now != ({1'b0, xlen} + {{LW{1'b0}}, 1'b1})) err <= 1'b1;
                            done <= gnt;
                            gnt  <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.C_GNT     = gnt;
    assign bus.C_XLEN    = xlen;
    assign bus.C_DONE    = done;
    assign bus.ERR       = err;
    assign bus.S_LENGTH  = xlen;
    assign bus.S_ADDR    = addr_r;
    assign bus.S_WRITE   = write_r;
    assign bus.S_REQUEST = (state == S_ISSUE);
    assign bus.S_DATA_IN = wdata_a[owner];
    assign bus.C_RDATA   = bus.S_DATA_OUT;
    assign bus.C_WR_ADV  = gnt & {N{bus.S_WR_ADV && (state == S_XFER)}};
    assign bus.C_RD_ADV  = gnt & {N{bus.S_RD_ADV && ((state == S_XFER) || (state == S_DRAIN))}};
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - scoreboard bench for sdram_arbiter with a behavioural controller model
module tb_sdram_arbiter;
    localparam int N = 3, AW = 24, DW = 16, LW = 9;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    sdram_arbiter_if #(.N(N), .AW(AW), .DW(DW), .LW(LW)) bus ();
    sdram_arbiter #(.N(N), .AW(AW), .DW(DW), .LW(LW), .DRAIN(2)) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus)
    );

    typedef struct {
        int client; int xlen; int addr; int beats; int issues; bit write;
    } exp_t;
    exp_t exp_q[$];

    int  total = 0, bad = 0, done_total = 0;
    int  target[N], done_cnt[N], wbeat[N];
    int  steal_req = 0, steal_used = 0;
    bit  late_rd = 0, abort = 0, end_req = 0, mon_done = 0;

    function automatic void chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    task automatic set_client(input int i, input bit wr, input int addr, input int len);
        bus.C_WRITE[i]          = wr;
        bus.C_ADDR[i*AW +: AW]  = AW'(addr);
        bus.C_LEN[i*LW +: LW]   = LW'(len);
    endtask

    task automatic push_exp(input int c, input int x, input int a, input int b, input int is, input bit w);
        exp_t e;
        e.client = c; e.xlen = x; e.addr = a; e.beats = b; e.issues = is; e.write = w;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int n);
        int cyc = 0;
        while (done_total < n && cyc < 2000) begin
            @(posedge CLK);
            cyc++;
        end
        @(posedge CLK);
        #1;
    endtask

    // Client agents: hold C_REQ until target completions, advance write word on each consumed beat.
    initial begin
        logic [N-1:0] snap_wr;
        for (int i = 0; i < N; i++) begin
            done_cnt[i] = 0; wbeat[i] = 0;
            bus.C_WDATA[i*DW +: DW] = DW'(32'hA000 | (i << 8));
        end
        bus.C_REQ = '0;
        forever begin
            @(negedge CLK);
            snap_wr = RESET ? '0 : bus.C_WR_ADV;
            for (int i = 0; i < N; i++) begin
                if (RESET) wbeat[i] = 0;
                else if (bus.C_DONE[i]) begin
                    done_cnt[i]++;
                    wbeat[i] = 0;
                end
                bus.C_REQ[i] = (done_cnt[i] < target[i]);
            end
            @(posedge CLK);
            #2;
            for (int i = 0; i < N; i++) begin
                if (RESET) wbeat[i] = 0;
                else if (snap_wr[i]) wbeat[i]++;
                bus.C_WDATA[i*DW +: DW] = DW'(32'hA000 | (i << 8) | wbeat[i]);
            end
        end
    end

    // Controller model: BUSY over the burst, optional refresh steal, optional late read beat.
    initial begin
        int len;
        bit wr;
        bus.S_BUSY = 0; bus.S_WR_ADV = 0; bus.S_RD_ADV = 0; bus.S_DATA_OUT = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (bus.S_REQUEST && !RESET) begin
                len = int'(bus.S_LENGTH);
                wr  = bus.S_WRITE;
                bus.S_BUSY = 1;
                if (steal_used < steal_req) begin
                    steal_used++;
                    @(posedge CLK); #1;
                    @(posedge CLK); #1;
                    bus.S_BUSY = 0;
                end else begin
                    for (int b = 0; b <= len; b++) begin
                        @(posedge CLK); #1;
                        if (abort) begin
                            bus.S_BUSY = 0; bus.S_WR_ADV = 0; bus.S_RD_ADV = 0;
                            break;
                        end
                        bus.S_WR_ADV = wr;
                        bus.S_RD_ADV = !wr && !late_rd;
                        bus.S_DATA_OUT = DW'(32'hD000 + b);
                    end
                    @(posedge CLK); #1;
                    bus.S_BUSY = 0; bus.S_WR_ADV = 0; bus.S_RD_ADV = 0;
                    if (late_rd && !wr && !abort) begin
                        @(posedge CLK); #1;
                        bus.S_RD_ADV = 1;
                        bus.S_DATA_OUT = 16'hD000;
                        @(posedge CLK); #1;
                        bus.S_RD_ADV = 0;
                    end
                end
            end
        end
    end

    // Monitor: pops the expected grant and checks every beat, issue and completion against it.
    initial begin
        exp_t cur;
        bit in_flight = 0, prev_req = 0, prev_reset = 0;
        int prev_gnt = 0, beats = 0, issues = 0, idle = 0;
        forever begin
            @(negedge CLK);
            if (prev_reset) begin
                chk("reset_ctrl", int'({bus.C_GNT, bus.C_DONE, bus.C_WR_ADV, bus.C_RD_ADV,
                                        bus.S_REQUEST, bus.ERR}), 0);
                chk("reset_fields", int'(bus.C_XLEN) | int'(bus.S_LENGTH) | int'(bus.S_ADDR), 0);
                in_flight = 0;
            end
            if (RESET) begin
                in_flight = 0;
            end else begin
                if (bus.C_GNT != '0 && int'(bus.C_GNT) != prev_gnt) begin
                    idle = 0;
                    if (exp_q.size() == 0) chk("grant_unexpected", int'(bus.C_GNT), 0);
                    else begin
                        cur = exp_q.pop_front();
                        chk("grant_owner", int'(bus.C_GNT), 1 << cur.client);
                        chk("grant_xlen", int'(bus.C_XLEN), cur.xlen);
                        in_flight = 1; beats = 0; issues = 0;
                    end
                end
                if (bus.S_REQUEST && !prev_req && in_flight) begin
                    issues++;
                    chk("issue_addr", int'(bus.S_ADDR), cur.addr);
                    chk("issue_len", int'(bus.S_LENGTH), cur.xlen);
                    chk("issue_write", int'(bus.S_WRITE), int'(cur.write));
                end
                if (bus.C_WR_ADV != '0) begin
                    idle = 0;
                    chk("wr_adv_owner", int'(bus.C_WR_ADV), in_flight ? (1 << cur.client) : 0);
                    chk("wr_data", int'(bus.S_DATA_IN), 32'hA000 | (cur.client << 8) | beats);
                    beats++;
                end
                if (bus.C_RD_ADV != '0) begin
                    idle = 0;
                    chk("rd_adv_owner", int'(bus.C_RD_ADV), in_flight ? (1 << cur.client) : 0);
                    chk("rd_data", int'(bus.C_RDATA), 32'hD000 + beats);
                    beats++;
                end
                if (bus.C_DONE != '0) begin
                    idle = 0;
                    if (!in_flight) chk("done_unexpected", int'(bus.C_DONE), 0);
                    else begin
                        chk("done_owner", int'(bus.C_DONE), 1 << cur.client);
                        chk("done_beats", beats, cur.beats);
                        chk("done_issues", issues, cur.issues);
                        chk("done_err", int'(bus.ERR), 0);
                        in_flight = 0;
                    end
                    done_total++;
                end
                if (in_flight || exp_q.size() > 0) begin
                    idle++;
                    if (idle > 300) begin
                        chk("watchdog_progress", idle, 0);
                        in_flight = 0; idle = 0;
                        exp_q.delete();
                    end
                end else idle = 0;
            end
            if (end_req && !mon_done) begin
                chk("final_queue_empty", exp_q.size(), 0);
                chk("final_idle", int'(in_flight), 0);
                mon_done = 1;
            end
            prev_gnt   = int'(bus.C_GNT);
            prev_req   = bus.S_REQUEST;
            prev_reset = RESET;
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            target[i] = 0;
            set_client(i, 1'b1, 32'h010000 * (i + 1), 0);
        end
        bus.S_MAX_LEN = LW'(380);
        RESET = 1;
        repeat (3) @(posedge CLK);
        #1 RESET = 0;

        // Round robin, all three holding requests with single-beat bursts.
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push_exp(i, 0, 32'h010000 * (i + 1), 1, 1, 1'b1);
        for (int i = 0; i < N; i++) target[i] = 2;
        wait_done(6);

        // Single write, client 1, four beats.
        set_client(1, 1'b1, 32'h001100, 3);
        push_exp(1, 3, 32'h001100, 4, 1, 1'b1);
        target[1] = 3;
        wait_done(7);

        // Clamp 300 down to MAX_LEN 20.
        bus.S_MAX_LEN = LW'(20);
        set_client(2, 1'b1, 32'h0A0000, 300);
        push_exp(2, 20, 32'h0A0000, 21, 1, 1'b1);
        target[2] = 3;
        wait_done(8);
        bus.S_MAX_LEN = LW'(380);

        // Refresh steal on the first issue: one retry, one completion.
        steal_req = 1;
        set_client(0, 1'b1, 32'h003300, 2);
        push_exp(0, 2, 32'h003300, 3, 2, 1'b1);
        target[0] = 3;
        wait_done(9);

        // Read whose only beat lands during DRAIN.
        late_rd = 1;
        set_client(1, 1'b0, 32'h004400, 0);
        push_exp(1, 0, 32'h004400, 1, 1, 1'b0);
        target[1] = 4;
        wait_done(10);
        late_rd = 0;

        // Reset in the middle of a client-0 burst; the grant never completes.
        set_client(0, 1'b1, 32'h005500, 7);
        push_exp(0, 7, 32'h005500, 8, 1, 1'b1);
        target[0] = 4;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            if (bus.C_WR_ADV[0]) break;
        end
        @(posedge CLK);
        #1;
        abort = 1; RESET = 1;
        target[0] = done_cnt[0];
        @(posedge CLK);
        #1 RESET = 0;
        repeat (3) @(posedge CLK);
        #1 abort = 0;

        // After reset client 0 wins over client 1 again.
        set_client(0, 1'b1, 32'h006600, 0);
        set_client(1, 1'b1, 32'h007700, 0);
        push_exp(0, 0, 32'h006600, 1, 1, 1'b1);
        push_exp(1, 0, 32'h007700, 1, 1, 1'b1);
        target[0] = done_cnt[0] + 1;
        target[1] = done_cnt[1] + 1;
        wait_done(12);
        repeat (4) @(posedge CLK);

        end_req = 1;
        for (int c = 0; c < 20 && !mon_done; c++) @(posedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Round-robin arbiter that shares one sdram controller port between N client masters. It holds each client's burst request, clamps burst length to the controller's refresh-safe MAX_LEN, and routes write-advance, read-advance and read data back to the owning client. It re-issues any request that a controller auto-refresh swallowed, then signals per-client completion. It sits between the DMA/video/CPU masters and the sdram controller instance.

Parameters:
N, 3, number of client ports (2..8)
AW, 24, address width
DW, 16, data width
LW, 9, length field width (value = beats-1)
DRAIN, 2, cycles to wait after S_BUSY falls so that the final delayed read-advance beats arrive

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
C_REQ  in  N  per-client request, level, held until C_DONE
C_WRITE  in  N  per-client direction, 1=write
C_ADDR  in  N*AW  per-client start address, packed, client i at [i*AW+:AW]
C_LEN  in  N*LW  per-client requested length-1, packed
C_WDATA  in  N*DW  per-client write data, packed
C_GNT  out  N  one-hot owner, held from grant through C_DONE
C_XLEN  out  LW  effective clamped length-1 of current grant
C_WR_ADV  out  N  write beat consumed; client presents next word
C_RD_ADV  out  N  read beat valid on C_RDATA
C_RDATA  out  DW  read data, broadcast
C_DONE  out  N  one-cycle completion pulse to owner
ERR  out  1  sticky; beat count mismatch
S_LENGTH  out  LW  to controller LENGTH
S_MAX_LEN  in  LW  from controller MAX_LEN
S_ADDR  out  AW  to controller ADDR
S_DATA_IN  out  DW  to controller DATA_IN
S_DATA_OUT  in  DW  from controller DATA_OUT
S_REQUEST  out  1  to controller REQUEST
S_WRITE  out  1  to controller WRITE
S_BUSY  in  1  from controller BUSY
S_WR_ADV  in  1  from controller WR_ADV
S_RD_ADV  in  1  from controller RD_ADV

Behaviour:
- Reset: state IDLE; C_GNT, C_DONE, C_WR_ADV, C_RD_ADV, S_REQUEST, ERR = 0; C_XLEN, S_LENGTH, S_ADDR = 0; rr pointer = N-1, so client 0 has first priority. Reset mid-transfer abandons the transfer and asserts no C_DONE.
- States:
  - IDLE: if any C_REQ, pick the first requester scanning from ptr+1 upward, with wrap. Register owner, addr, write, and xlen = min(C_LEN[owner], S_MAX_LEN). Set C_GNT, set ptr = owner. Go to ISSUE next cycle.
  - ISSUE: S_REQUEST=1. Go to XFER on the first cycle S_BUSY=1. S_REQUEST drops in the same edge.
  - XFER: S_REQUEST=0. Count S_WR_ADV and S_RD_ADV beats. Go to DRAIN when S_BUSY=0.
  - DRAIN: hold DRAIN cycles while still counting S_RD_ADV. On the last cycle:
    - beats == xlen+1: go to IDLE and pulse C_DONE[owner] in the first IDLE cycle. C_GNT clears at the same time.
    - beats == 0: a refresh consumed the request. Clear the counter, go to ISSUE, keep the latched xlen.
    - otherwise: set ERR, complete as the success case.
- S_ADDR, S_WRITE and S_LENGTH are registered from the latched values and stay stable for ISSUE through DRAIN.
- S_DATA_IN = C_WDATA[owner], combinational from the latched owner.
- C_WR_ADV[i] = S_WR_ADV & owner==i & state==XFER.
- C_RD_ADV[i] = S_RD_ADV & owner==i & state in {XFER, DRAIN}.
- C_RDATA = S_DATA_OUT, unregistered.
- The beat counter is LW+1 bits, so the maximum burst (2^LW beats) does not wrap.
- A new grant can be made in the same IDLE cycle that C_DONE pulses. The finishing client must drop C_REQ on C_DONE, or it is eligible again at the lowest priority.
- A client dropping C_REQ after grant has no effect: the transfer completes.
- S_MAX_LEN is sampled only at grant.

Test Plan:
- Single write: client1 requests, LEN=3, MAX_LEN=380 -> C_GNT=010, S_REQUEST held until S_BUSY; 4 C_WR_ADV[1] pulses; C_DONE[1] one cycle; S_DATA_IN tracks C_WDATA[1].
- Round-robin: all 3 clients hold C_REQ, LEN=0 -> grant order 0,1,2,0,1,2; no client is granted twice in a row.
- Clamp: LEN=300, MAX_LEN=20 -> C_XLEN=20, S_LENGTH=20; exactly 21 beats, then C_DONE.
- Refresh steal: controller model enters refresh on the issued request (BUSY pulse, no beats) -> arbiter re-issues the same addr/len; exactly one C_DONE; ERR=0.
- Read drain: read LEN=0 whose RD_ADV arrives 1 cycle after BUSY falls -> C_RD_ADV[owner] pulse captured in DRAIN; C_RDATA matches model data; C_DONE after DRAIN.
- Reset in XFER: assert RESET mid-burst -> all outputs 0 next cycle; no C_DONE; next grant goes to client 0.
